pcm_deserializer: RTL

//  Serial-to-parallel receiver for the 16-bit stereo PCM bus driven by the serializer/DAC side.

---
 rtl/pcm_deserializer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pcm_deserializer.sv
// rtl/pcm_deserializer.sv - I2S-style stereo PCM receiver with framing check and ready/valid output
module pcm_deserializer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  bit_clock_in,
    input  logic                  rst_active_low,
    input  logic                  serial_data_in,
    input  logic                  LR_select,
    output logic [DATA_WIDTH-1:0] pcm_data_left,
    output logic [DATA_WIDTH-1:0] pcm_data_right,
    output logic                  pcm_data_valid,
    input  logic                  pcm_data_ready,
    output logic                  overrun,
    output logic                  frame_error,
    output logic                  locked
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] ST_UNSYNC = 2'd0;
    localparam logic [1:0] ST_LEFT   = 2'd1;
    localparam logic [1:0] ST_RIGHT  = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] left_sr;
    logic [DATA_WIDTH-1:0] right_sr;
    logic                  ws_d;

    logic                  ws_edge;
    logic                  ws_fall;
    logic                  ws_rise;
    logic                  last_bit;
    logic                  in_word;
    logic                  word_ok;
    logic                  word_err;
    logic                  frame_done;
    logic [DATA_WIDTH-1:0] right_word;

    // Word-select edge detection and per-edge framing decisions
    always_comb begin
        ws_edge    = LR_select ^ ws_d;
        ws_fall    = ws_edge & ~LR_select;
        ws_rise    = ws_edge & LR_select;
        last_bit   = (bit_cnt == CW'(DATA_WIDTH - 1));
        in_word    = (state == ST_LEFT) || (state == ST_RIGHT);
        word_ok    = last_bit && ((state == ST_LEFT) ? ws_rise : ws_fall);
        // An edge mid-word, or a missing/wrong-direction edge on the LSB, breaks the frame
        word_err   = in_word && (last_bit ? !word_ok : ws_edge);
        frame_done = (state == ST_RIGHT) && last_bit && ws_fall;
        right_word = {right_sr[DATA_WIDTH-2:0], serial_data_in};
    end

    // Framing state machine and channel shift registers
    always_ff @(posedge bit_clock_in or negedge rst_active_low) begin
        if (!rst_active_low) begin
            state    <= ST_UNSYNC;
            bit_cnt  <= '0;
            left_sr  <= '0;
            right_sr <= '0;
            ws_d     <= 1'b0;
        end else begin
            ws_d <= LR_select;
            if (word_err) begin
                // A falling edge is itself a valid left-word start, so resync on it
                state   <= ws_fall ? ST_LEFT : ST_UNSYNC;
                bit_cnt <= '0;
            end else if (state == ST_UNSYNC) begin
                if (ws_fall) begin
                    state   <= ST_LEFT;
                    bit_cnt <= '0;
                end
            end else begin
                if (state == ST_LEFT) begin
                    left_sr <= {left_sr[DATA_WIDTH-2:0], serial_data_in};
                end else begin
                    right_sr <= right_word;
                end
                if (last_bit) begin
                    state   <= (state == ST_LEFT) ? ST_RIGHT : ST_LEFT;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    // Output pair register, handshake, and status pulses
    always_ff @(posedge bit_clock_in or negedge rst_active_low) begin
        if (!rst_active_low) begin
            pcm_data_left  <= '0;
            pcm_data_right <= '0;
            pcm_data_valid <= 1'b0;
            overrun        <= 1'b0;
            frame_error    <= 1'b0;
            locked         <= 1'b0;
        end else begin
            overrun     <= 1'b0;
            frame_error <= word_err;
            if (word_err) begin
                locked <= 1'b0;
            end
            if (frame_done) begin
                locked <= 1'b1;
                if (pcm_data_valid && !pcm_data_ready) begin
                    // Held pair has priority; the new one is lost
                    overrun <= 1'b1;
                end else begin
                    pcm_data_left  <= left_sr;
                    pcm_data_right <= right_word;
                    pcm_data_valid <= 1'b1;
                end
            end else if (pcm_data_valid && pcm_data_ready) begin
                pcm_data_valid <= 1'b0;
            end
        end
    end

endmodule
